// File: rtl/uart_fifo_ctrl_if.sv
// Bus bundle between the CPU-side FIFO controls, the FIFO controller and the byte-level uart core.
// slave is the controller's view; master is the surrounding CPU/core environment.
interface uart_fifo_ctrl_if #(
  parameter int unsigned AW = 4
);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    tx_data;
  logic          tx_push;
  logic          tx_full;
  logic [CW-1:0] tx_count;
  logic [7:0]    rx_data;
  logic          rx_pop;
  logic          rx_empty;
  logic [CW-1:0] rx_count;
  logic          rx_overrun;
  logic          clr_overrun;
  logic [7:0]    core_data_in;
  logic          core_enable_write;
  logic          core_busy_write;
  logic [7:0]    core_data_out;
  logic          core_data_avail;
  logic          core_enable_read;

  modport slave (
    input  tx_data, tx_push, rx_pop, clr_overrun,
           core_busy_write, core_data_out, core_data_avail,
    output tx_full, tx_count, rx_data, rx_empty, rx_count, rx_overrun,
           core_data_in, core_enable_write, core_enable_read
  );

  modport master (
    output tx_data, tx_push, rx_pop, clr_overrun,
           core_busy_write, core_data_out, core_data_avail,
    input  tx_full, tx_count, rx_data, rx_empty, rx_count, rx_overrun,
           core_data_in, core_enable_write, core_enable_read
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// TX/RX byte FIFOs sequencing the uart core's write and read handshakes.
// Status is decoded from registered counts; there is no input-to-output combinational path.
module uart_fifo_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_fifo_ctrl_if.slave bus
);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;
  typedef enum logic       {RX_IDLE, RX_ACK} rx_state_e;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_cnt, rx_cnt;

  tx_state_e  tx_state, tx_state_d;
  rx_state_e  rx_state, rx_state_d;
  logic       enw_q, enw_d, enr_q, enr_d;
  logic [7:0] din_q, din_d;
  logic       overrun_q;

  logic tx_push_ok, tx_pop, rx_push, rx_drop, rx_pop_ok;

  assign tx_push_ok = bus.tx_push && (tx_cnt != FULL_CNT);
  assign rx_pop_ok  = bus.rx_pop && (rx_cnt != '0);

  // TX sequencer: launch one byte, then wait for the core to take and finish the frame
  always_comb begin
    tx_state_d = tx_state;
    enw_d      = 1'b0;
    din_d      = din_q;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if ((tx_cnt != '0) && !bus.core_busy_write) begin
          din_d      = tx_mem[tx_rd_ptr];
          enw_d      = 1'b1;
          tx_pop     = 1'b1;
          tx_state_d = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: if (bus.core_busy_write) tx_state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!bus.core_busy_write) tx_state_d = TX_IDLE;
      default:      tx_state_d = TX_IDLE;
    endcase
  end

  // RX sequencer: ACK skips the cycle where data_avail still reflects the acknowledged byte
  always_comb begin
    rx_state_d = rx_state;
    enr_d      = 1'b0;
    rx_push    = 1'b0;
    rx_drop    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (bus.core_data_avail) begin
          enr_d      = 1'b1;
          rx_state_d = RX_ACK;
          if (rx_cnt != FULL_CNT) rx_push = 1'b1;
          else                    rx_drop = 1'b1;
        end
      end
      RX_ACK: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state  <= TX_IDLE;
      rx_state  <= RX_IDLE;
      enw_q     <= 1'b0;
      enr_q     <= 1'b0;
      din_q     <= 8'h00;
      overrun_q <= 1'b0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
    end else begin
      tx_state <= tx_state_d;
      rx_state <= rx_state_d;
      enw_q    <= enw_d;
      enr_q    <= enr_d;
      din_q    <= din_d;
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (rx_push)    rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push_ok) - CW'(tx_pop);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop_ok);
      // A dropped byte outranks a same-cycle clear
      if (rx_drop)              overrun_q <= 1'b1;
      else if (bus.clr_overrun) overrun_q <= 1'b0;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and counts
  always_ff @(posedge clk) begin
    if (reset && tx_push_ok) tx_mem[tx_wr_ptr] <= bus.tx_data;
    if (reset && rx_push)    rx_mem[rx_wr_ptr] <= bus.core_data_out;
  end

  assign bus.tx_full           = (tx_cnt == FULL_CNT);
  assign bus.tx_count          = tx_cnt;
  assign bus.rx_data           = rx_mem[rx_rd_ptr];
  assign bus.rx_empty          = (rx_cnt == '0);
  assign bus.rx_count          = rx_cnt;
  assign bus.rx_overrun        = overrun_q;
  assign bus.core_data_in      = din_q;
  assign bus.core_enable_write = enw_q;
  assign bus.core_enable_read  = enr_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: reset, TX launch/full/drain, RX capture/overrun, simultaneous push+pop.
// A small core model drives busy_write and logs every byte launched into the core.
module tb_uart_fifo_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_fifo_ctrl_if #(.AW(4)) bus ();

  uart_fifo_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Core model: after each write pulse, busy is high for busy_len cycles starting the next cycle
  logic [7:0] tx_log[$];
  int         busy_left = 0;
  int         busy_len  = 10;
  logic       core_hold = 1'b0;

  always @(posedge clk) begin
    #1;
    if (busy_left > 0) begin
      bus.core_busy_write = 1'b1;
      busy_left--;
    end else begin
      bus.core_busy_write = core_hold;
    end
    if (bus.core_enable_write === 1'b1) begin
      tx_log.push_back(bus.core_data_in);
      busy_left = busy_len;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int rx_acks = 0;

  // One core delivery: data_avail for one cycle, then one cycle idle
  task automatic rx_deliver(input logic [7:0] b, input logic clr);
    bus.core_data_avail = 1'b1;
    bus.core_data_out   = b;
    bus.clr_overrun     = clr;
    tick();
    if (bus.core_enable_read === 1'b1) rx_acks++;
    bus.core_data_avail = 1'b0;
    bus.clr_overrun     = 1'b0;
    tick();
  endtask

  task automatic wait_log(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (tx_log.size() >= n) break;
      tick();
    end
  endtask

  initial begin
    logic stray;
    int   pulses;

    // Reset held with activity on both sides
    reset               = 1'b0;
    bus.tx_push         = 1'b1;
    bus.tx_data         = 8'h11;
    bus.rx_pop          = 1'b0;
    bus.clr_overrun     = 1'b0;
    bus.core_data_avail = 1'b1;
    bus.core_data_out   = 8'h22;
    tick();
    check_eq("rst_enw_1", 32'(bus.core_enable_write), 0);
    check_eq("rst_enr_1", 32'(bus.core_enable_read), 0);
    tick();
    check_eq("rst_enw_2", 32'(bus.core_enable_write), 0);
    check_eq("rst_enr_2", 32'(bus.core_enable_read), 0);
    reset               = 1'b1;
    bus.tx_push         = 1'b0;
    bus.core_data_avail = 1'b0;
    tick();
    check_eq("rst_tx_count", 32'(bus.tx_count), 0);
    check_eq("rst_tx_full", 32'(bus.tx_full), 0);
    check_eq("rst_rx_empty", 32'(bus.rx_empty), 1);
    check_eq("rst_rx_count", 32'(bus.rx_count), 0);
    check_eq("rst_overrun", 32'(bus.rx_overrun), 0);
    check_eq("rst_data_in", 32'(bus.core_data_in), 0);

    // TX launch: push in cycle 0, pulse in cycle 2
    bus.tx_data = 8'hA5;
    bus.tx_push = 1'b1;
    tick();
    bus.tx_push = 1'b0;
    check_eq("tx_c1_count", 32'(bus.tx_count), 1);
    check_eq("tx_c1_enw", 32'(bus.core_enable_write), 0);
    tick();
    check_eq("tx_c2_enw", 32'(bus.core_enable_write), 1);
    check_eq("tx_c2_data", 32'(bus.core_data_in), 32'hA5);
    check_eq("tx_c2_count", 32'(bus.tx_count), 0);
    tick();
    check_eq("tx_c3_enw", 32'(bus.core_enable_write), 0);
    bus.tx_data = 8'h3C;
    bus.tx_push = 1'b1;
    tick();
    bus.tx_push = 1'b0;
    // busy high cycles 3..12, low at 13 -> IDLE at 14 -> pulse at 15
    stray = 1'b0;
    for (int c = 4; c <= 14; c++) begin
      stray |= bus.core_enable_write;
      tick();
    end
    check_eq("tx_no_early_pulse", 32'(stray), 0);
    check_eq("tx_c15_enw", 32'(bus.core_enable_write), 1);
    check_eq("tx_c15_data", 32'(bus.core_data_in), 32'h3C);
    repeat (20) tick();
    check_eq("tx_log_two", 32'(tx_log.size()), 2);

    // TX full with the core held busy
    core_hold = 1'b1;
    repeat (2) tick();
    for (int i = 0; i <= 16; i++) begin
      bus.tx_data = 8'(i);
      bus.tx_push = 1'b1;
      tick();
      if (i == 14) check_eq("txf_not_full_15", 32'(bus.tx_full), 0);
      if (i == 15) begin
        check_eq("txf_full_16", 32'(bus.tx_full), 1);
        check_eq("txf_count_16", 32'(bus.tx_count), 16);
      end
    end
    bus.tx_push = 1'b0;
    check_eq("txf_count_after_17", 32'(bus.tx_count), 16);
    tx_log.delete();
    busy_len  = 2;
    core_hold = 1'b0;
    wait_log(16, 400);
    repeat (20) tick();
    check_eq("txf_drain_size", 32'(tx_log.size()), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < tx_log.size()) check_eq($sformatf("txf_order_%0d", i), 32'(tx_log[i]), 32'(i));
    end
    check_eq("txf_drained_count", 32'(bus.tx_count), 0);

    // TX push coincident with launch at count 3
    core_hold = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      bus.tx_data = 8'(8'h61 + i);
      bus.tx_push = 1'b1;
      tick();
    end
    bus.tx_push = 1'b0;
    check_eq("txs_count_3", 32'(bus.tx_count), 3);
    tx_log.delete();
    core_hold = 1'b0;
    tick();
    bus.tx_data = 8'h64;
    bus.tx_push = 1'b1;
    tick();
    bus.tx_push = 1'b0;
    check_eq("txs_count_kept", 32'(bus.tx_count), 3);
    check_eq("txs_enw", 32'(bus.core_enable_write), 1);
    check_eq("txs_data", 32'(bus.core_data_in), 32'h61);
    wait_log(4, 400);
    check_eq("txs_log_size", 32'(tx_log.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < tx_log.size()) check_eq($sformatf("txs_order_%0d", i), 32'(tx_log[i]), 32'(8'h61 + i));
    end

    // RX capture: data_avail held two cycles yields one acknowledge
    pulses = 0;
    bus.core_data_avail = 1'b1;
    bus.core_data_out   = 8'h5A;
    tick();
    pulses += int'(bus.core_enable_read);
    tick();
    pulses += int'(bus.core_enable_read);
    bus.core_data_avail = 1'b0;
    tick();
    pulses += int'(bus.core_enable_read);
    check_eq("rx_one_pulse", 32'(pulses), 1);
    check_eq("rx_count_1", 32'(bus.rx_count), 1);
    check_eq("rx_head_5a", 32'(bus.rx_data), 32'h5A);
    bus.rx_pop = 1'b1;
    tick();
    bus.rx_pop = 1'b0;
    check_eq("rx_empty_after_pop", 32'(bus.rx_empty), 1);
    bus.rx_pop = 1'b1;
    tick();
    bus.rx_pop = 1'b0;
    check_eq("rx_underflow_ignored", 32'(bus.rx_count), 0);

    // RX overrun: 17th byte dropped but acknowledged; its set beats a same-cycle clear
    rx_acks = 0;
    for (int i = 0; i < 16; i++) rx_deliver(8'(8'h80 + i), 1'b0);
    check_eq("rxo_no_overrun_16", 32'(bus.rx_overrun), 0);
    rx_deliver(8'hEE, 1'b1);
    check_eq("rxo_acks", 32'(rx_acks), 17);
    check_eq("rxo_count", 32'(bus.rx_count), 16);
    check_eq("rxo_sticky_set_wins", 32'(bus.rx_overrun), 1);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    check_eq("rxo_cleared", 32'(bus.rx_overrun), 0);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("rxo_data_%0d", i), 32'(bus.rx_data), 32'(8'h80 + i));
      bus.rx_pop = 1'b1;
      tick();
      bus.rx_pop = 1'b0;
    end
    check_eq("rxo_empty", 32'(bus.rx_empty), 1);

    // RX capture coincident with pop at count 5
    for (int i = 0; i < 5; i++) rx_deliver(8'(8'h40 + i), 1'b0);
    check_eq("rxs_count_5", 32'(bus.rx_count), 5);
    bus.core_data_avail = 1'b1;
    bus.core_data_out   = 8'h45;
    bus.rx_pop          = 1'b1;
    tick();
    bus.core_data_avail = 1'b0;
    bus.rx_pop          = 1'b0;
    check_eq("rxs_ack", 32'(bus.core_enable_read), 1);
    check_eq("rxs_count_kept", 32'(bus.rx_count), 5);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rxs_data_%0d", i), 32'(bus.rx_data), 32'(8'h41 + i));
      bus.rx_pop = 1'b1;
      tick();
      bus.rx_pop = 1'b0;
    end
    check_eq("rxs_empty", 32'(bus.rx_empty), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
